video_console: RTL
==================

// Module: video_console
// PURPOSE
//  Text-console writer feeding the display-memory write port of video_main.
//  It accepts a byte stream of characters and control codes over valid/ready,
//  tracks a cursor, and emits one-word writes {attr,char}. It also performs
//  the clears: the full screen at reset or on form-feed, and a single line on
//  newline or wrap. Sits in video_top in place of the video_test writer.
// PARAMETERS
//  COLS       40     visible text columns (cursor x range 0..COLS-1)
//  ROWS       16     visible text rows (cursor y range 0..ROWS-1)
//  CLR_ATTR   8'h0F  attribute used when clearing cells (clear char = 8'h20)
// PORTS
//  clk          in   1   design clock (PLL output)
//  reset        in   1   synchronous, active-high reset
//  char_valid_i in   1   character byte available
//  char_data_i  in   8   character byte / control code
//  char_attr_i  in   8   attribute for printable char, sampled on accept
//  char_ready_o out  1   console can accept a byte this cycle
//  line_len_i   in   disp_addr_t  words per row in display memory (>= COLS)
//  wr_en_o      out  1   display memory write strobe
//  wr_addr_o    out  disp_addr_t  display memory word address
//  wr_data_o    out  disp_data_t  {attr[7:0], char[7:0]}
//  cursor_x_o   out  $clog2(COLS)  current column
//  cursor_y_o   out  $clog2(ROWS)  current row
//  busy_o       out  1   clear in progress (== !char_ready_o)
// BEHAVIOUR
//  - One clock, clk. Reset is synchronous and active-high. On reset all
//    outputs are 0 except busy_o=1. The FSM enters CLR_ALL, cursor=(0,0),
//    row_base=0.
//  - Reset asserted mid-clear restarts CLR_ALL from address 0.
//  - FSM states: CLR_ALL, CLR_LINE, IDLE. char_ready_o=1 only in IDLE.
//    Accept happens when char_valid_i & char_ready_o.
//  - CLR_ALL: one write per cycle of {CLR_ATTR,8'h20}, rows 0..ROWS-1,
//    columns 0..COLS-1, address = row_base + col, with row_base stepping by
//    line_len_i. Total is ROWS*COLS writes. At the end: cursor=(0,0),
//    row_base=0, state goes to IDLE.
//  - CLR_LINE: COLS writes to the cursor row (cursor_y), then IDLE.
//  - Accepted byte in IDLE:
//    * 8'h0D CR: x=0. No write.
//    * 8'h0A LF: x=0, y=next_y, then CLR_LINE on the new row.
//    * 8'h08 BS: x=x-1 if x>0, else no change. No write.
//    * 8'h0C FF: go to CLR_ALL.
//    * any other byte: write {char_attr_i,byte} at row_base+x. If x==COLS-1,
//      x=0, y=next_y, then CLR_LINE. Else x=x+1.
//  - next_y = (y==ROWS-1) ? 0 : y+1. Wrap goes to the top row; there is no
//    scroll. row_base wraps to 0 together with y.
//  - Latency: wr_en_o pulses exactly 1 cycle after the accepting edge, for
//    one cycle. The cursor updates on the same cycle.
//  - Registered outputs; no combinational path from char_valid_i to any
//    output.
//  - Address arithmetic uses disp_addr_t width and wraps modulo 2^width.
//    There is no multiplier; row_base is accumulated.
//  - line_len_i must be stable while busy_o=1. Changing it in IDLE takes
//    effect at the next clear or row change.
// STRUCTURE
//  - Package video_package (v::) holds: disp_addr_t, disp_data_t,
//    CHAR_CR/LF/BS/FF constants, CLEAR_CHAR, and the console_state_t enum.
//  - Single module, no sub-module. A counter pair (col,row) plus the
//    row_base accumulator is shared between clearing and cursor tracking.
// TESTING
//  1. Reset 1 cycle, line_len=40: exactly 640 writes of 16'h0F20, addr 0..639
//     in order. Then char_ready_o=1, cursor (0,0).
//  2. 'A' (8'h41) with attr 8'h1F at (0,0): wr_en 1 cycle later, addr 0,
//     data 16'h1F41. Cursor (1,0).
//  3. 40 printables on row 0: the last goes to addr 39, cursor (0,1). Then 40
//     clear writes to addr 40..79 with ready=0, then ready=1.
//  4. Cursor at row 15, LF: cursor (0,0). Clear writes to addr 0..39.
//     BS at x=0: no write, cursor unchanged.
//  5. FF at (5,3): full 640-write clear, home.
//     Reset asserted after 100 clear writes: clear restarts at addr 0.
//  6. char_valid held through a clear: byte accepted only in the first IDLE
//     cycle, written exactly once, not lost or duplicated.

Source files
------------

// File: rtl/video_console_pkg.sv
// Shared types and constants for the text-console writer and its display-memory port.
package video_console_pkg;

  localparam int ADDR_W = 12;
  localparam int DATA_W = 16;

  typedef logic [ADDR_W-1:0] disp_addr_t;
  typedef logic [DATA_W-1:0] disp_data_t;

  // Control codes recognised by the console
  localparam logic [7:0] CHAR_CR    = 8'h0D;
  localparam logic [7:0] CHAR_LF    = 8'h0A;
  localparam logic [7:0] CHAR_BS    = 8'h08;
  localparam logic [7:0] CHAR_FF    = 8'h0C;
  localparam logic [7:0] CLEAR_CHAR = 8'h20;

  typedef enum logic [1:0] {
    ST_CLR_ALL  = 2'd0,
    ST_CLR_LINE = 2'd1,
    ST_IDLE     = 2'd2
  } console_state_t;

  // One display cell: attribute in the upper byte, character in the lower byte
  function automatic disp_data_t pack_cell(input logic [7:0] attr, input logic [7:0] ch);
    return {attr, ch};
  endfunction

endpackage

// File: rtl/video_console.sv
// Text-console writer: turns a byte stream into display-memory writes,
// tracking a cursor and performing full-screen and single-line clears.
module video_console
  import video_console_pkg::*;
#(
  parameter int         COLS     = 40,
  parameter int         ROWS     = 16,
  parameter logic [7:0] CLR_ATTR = 8'h0F
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     char_valid_i,
  input  logic [7:0]               char_data_i,
  input  logic [7:0]               char_attr_i,
  output logic                     char_ready_o,
  input  disp_addr_t               line_len_i,
  output logic                     wr_en_o,
  output disp_addr_t               wr_addr_o,
  output disp_data_t               wr_data_o,
  output logic [$clog2(COLS)-1:0]  cursor_x_o,
  output logic [$clog2(ROWS)-1:0]  cursor_y_o,
  output logic                     busy_o
);

  localparam int XW = $clog2(COLS);
  localparam int YW = $clog2(ROWS);

  localparam logic [XW-1:0] LAST_X = XW'(COLS - 1);
  localparam logic [YW-1:0] LAST_Y = YW'(ROWS - 1);

  // The cursor pair doubles as the sweep counter during clears: a clear always
  // finishes with x back at 0, and a full clear finishes with y back at 0.
  console_state_t r_state;
  logic [XW-1:0]  r_cur_x;
  logic [YW-1:0]  r_cur_y;
  disp_addr_t     r_row_base;
  logic           r_ready;
  logic           r_wr_en;
  disp_addr_t     r_wr_addr;
  disp_data_t     r_wr_data;

  logic           w_last_x;
  logic           w_last_y;
  logic [YW-1:0]  w_next_y;
  disp_addr_t     w_next_base;
  disp_addr_t     w_cell_addr;
  logic           w_accept;
  disp_data_t     w_clear_cell;

  // Cursor/row-advance arithmetic shared by clears, newline and wrap
  always_comb begin
    w_last_x     = (r_cur_x == LAST_X);
    w_last_y     = (r_cur_y == LAST_Y);
    w_next_y     = w_last_y ? '0 : r_cur_y + YW'(1);
    w_next_base  = w_last_y ? '0 : r_row_base + line_len_i;
    w_cell_addr  = r_row_base + disp_addr_t'(r_cur_x);
    w_accept     = char_valid_i & r_ready;
    w_clear_cell = pack_cell(CLR_ATTR, CLEAR_CHAR);
  end

  // Console FSM, cursor tracking and registered write port
  always_ff @(posedge clk) begin
    // NOTE: reset is sampled on the clock edge like any other input, so a
    // reset arriving mid-clear simply restarts the sweep from address 0.
    if (reset) begin
      r_state    <= ST_CLR_ALL;
      r_cur_x    <= '0;
      r_cur_y    <= '0;
      r_row_base <= '0;
      r_ready    <= 1'b0;
      r_wr_en    <= 1'b0;
      r_wr_addr  <= '0;
      r_wr_data  <= '0;
    end else begin
      // NOTE: all state here uses non-blocking assignment so every register
      // sees the pre-edge values of the others, whatever the statement order.
      r_wr_en <= 1'b0;

      case (r_state)
        ST_CLR_ALL: begin
          r_wr_en   <= 1'b1;
          r_wr_addr <= w_cell_addr;
          r_wr_data <= w_clear_cell;
          if (w_last_x) begin
            r_cur_x <= '0;
            if (w_last_y) begin
              r_cur_y    <= '0;
              r_row_base <= '0;
              r_state    <= ST_IDLE;
              r_ready    <= 1'b1;
            end else begin
              r_cur_y    <= r_cur_y + YW'(1);
              r_row_base <= r_row_base + line_len_i;
            end
          end else begin
            r_cur_x <= r_cur_x + XW'(1);
          end
        end

        ST_CLR_LINE: begin
          r_wr_en   <= 1'b1;
          r_wr_addr <= w_cell_addr;
          r_wr_data <= w_clear_cell;
          if (w_last_x) begin
            r_cur_x <= '0;
            r_state <= ST_IDLE;
            r_ready <= 1'b1;
          end else begin
            r_cur_x <= r_cur_x + XW'(1);
          end
        end

        ST_IDLE: begin
          if (w_accept) begin
            case (char_data_i)
              CHAR_CR: begin
                r_cur_x <= '0;
              end
              CHAR_LF: begin
                r_cur_x    <= '0;
                r_cur_y    <= w_next_y;
                r_row_base <= w_next_base;
                r_state    <= ST_CLR_LINE;
                r_ready    <= 1'b0;
              end
              CHAR_BS: begin
                if (r_cur_x != '0) begin
                  r_cur_x <= r_cur_x - XW'(1);
                end
              end
              CHAR_FF: begin
                r_cur_x    <= '0;
                r_cur_y    <= '0;
                r_row_base <= '0;
                r_state    <= ST_CLR_ALL;
                r_ready    <= 1'b0;
              end
              default: begin
                r_wr_en   <= 1'b1;
                r_wr_addr <= w_cell_addr;
                r_wr_data <= pack_cell(char_attr_i, char_data_i);
                if (w_last_x) begin
                  r_cur_x    <= '0;
                  r_cur_y    <= w_next_y;
                  r_row_base <= w_next_base;
                  r_state    <= ST_CLR_LINE;
                  r_ready    <= 1'b0;
                end else begin
                  r_cur_x <= r_cur_x + XW'(1);
                end
              end
            endcase
          end
        end

        default: begin
          r_state    <= ST_CLR_ALL;
          r_cur_x    <= '0;
          r_cur_y    <= '0;
          r_row_base <= '0;
          r_ready    <= 1'b0;
        end
      endcase
    end
  end

  assign char_ready_o = r_ready;
  assign busy_o       = ~r_ready;
  assign wr_en_o      = r_wr_en;
  assign wr_addr_o    = r_wr_addr;
  assign wr_data_o    = r_wr_data;
  assign cursor_x_o   = r_cur_x;
  assign cursor_y_o   = r_cur_y;

endmodule
